// File: rtl/voice_scheduler_pkg.sv
// Shared types and constants for the voice scheduler: FSM state encoding,
// the default key count and the per-key phase increment table.
package voice_pkg;

    localparam int DEF_NUM_KEYS = 12;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_ACCUM,
        ST_DONE
    } state_t;

    // round(f_k * 2^32 / 16384), key 0 = C4 ... key 11 = B4 (440 Hz at key 9)
    localparam logic [31:0] PHASE_INC [DEF_NUM_KEYS] = '{
        32'd68584735,  32'd72661074,  32'd76981207,  32'd81560863,
        32'd86410527,  32'd91548549,  32'd96990659,  32'd102760448,
        32'd108868403, 32'd115343360, 32'd122201047, 32'd129467679
    };

    // Phase increment for a key index; unknown keys do not advance.
    function automatic logic [31:0] phase_inc(input logic [31:0] key);
        if (key < 32'(DEF_NUM_KEYS)) begin
            return PHASE_INC[key[3:0]];
        end
        return 32'd0;
    endfunction

endpackage

// File: rtl/voice_scheduler_allocator.sv
// Touch edge detection and voice table (active flag + key per voice).
// Releases free voices first, then presses fill the lowest free voice in
// ascending key order. o_phase_clr marks every voice written this cycle so
// the owner of the phase registers can zero them.
module voice_allocator
    import voice_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter int NUM_KEYS   = DEF_NUM_KEYS,
    parameter int KEY_W      = $clog2(NUM_KEYS)
) (
    input  logic                                clk_in,
    input  logic                                rst_in,
    input  logic [NUM_KEYS-1:0]                 i_touch_status,
    input  logic                                i_touch_valid,
    output logic [NUM_VOICES-1:0]               o_active,
    output logic [NUM_VOICES-1:0][KEY_W-1:0]    o_key,
    output logic [NUM_VOICES-1:0]               o_phase_clr,
    output logic                                o_drop
);

    logic [NUM_KEYS-1:0]              r_prev;
    logic [NUM_VOICES-1:0]            r_active;
    logic [NUM_VOICES-1:0][KEY_W-1:0] r_key;
    logic                             r_drop;

    logic [NUM_KEYS-1:0]              w_pressed;
    logic [NUM_KEYS-1:0]              w_released;
    logic [NUM_VOICES-1:0]            w_active_nxt;
    logic [NUM_VOICES-1:0][KEY_W-1:0] w_key_nxt;
    logic [NUM_VOICES-1:0]            w_clr;
    logic                             w_drop;
    logic                             w_found;

    // Compute the updated voice table: releases first, then presses
    always_comb begin
        w_pressed    = i_touch_status & ~r_prev;
        w_released   = r_prev & ~i_touch_status;
        w_active_nxt = r_active;
        w_key_nxt    = r_key;
        w_clr        = '0;
        w_drop       = 1'b0;
        w_found      = 1'b0;
        if (i_touch_valid) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (r_active[v] && w_released[r_key[v]]) begin
                    w_active_nxt[v] = 1'b0;
                    w_clr[v]        = 1'b1;
                end
            end
            for (int k = 0; k < NUM_KEYS; k++) begin
                if (w_pressed[k]) begin
                    w_found = 1'b0;
                    for (int v = 0; v < NUM_VOICES; v++) begin
                        if (!w_found && !w_active_nxt[v]) begin
                            w_active_nxt[v] = 1'b1;
                            w_key_nxt[v]    = KEY_W'(k);
                            w_clr[v]        = 1'b1;
                            w_found         = 1'b1;
                        end
                    end
                    if (!w_found) begin
                        w_drop = 1'b1;
                    end
                end
            end
        end
    end

    // Voice table and previous-touch registers, updated on each valid sample
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_prev   <= '0;
            r_active <= '0;
            r_key    <= '0;
            r_drop   <= 1'b0;
        end else begin
            r_drop <= w_drop;
            if (i_touch_valid) begin
                r_prev   <= i_touch_status;
                r_active <= w_active_nxt;
                r_key    <= w_key_nxt;
            end
        end
    end

    assign o_active    = r_active;
    assign o_key       = r_key;
    assign o_phase_clr = w_clr;
    assign o_drop      = r_drop;

endmodule

// File: rtl/voice_scheduler.sv
// Polyphonic voice scheduler: on each sample tick walks every voice through
// ISSUE/WAIT/ACCUM on one shared wavetable read port, sums active voices into
// a signed mix and advances their phase accumulators.
module voice_scheduler
    import voice_pkg::*;
#(
    parameter int NUM_VOICES   = 4,
    parameter int NUM_KEYS     = DEF_NUM_KEYS,
    parameter int PHASE_WIDTH  = 32,
    parameter int ADDR_WIDTH   = 8,
    parameter int SAMPLE_WIDTH = 8,
    parameter int BRAM_LATENCY = 2
) (
    input  logic                                              clk_in,
    input  logic                                              rst_in,
    input  logic                                              sample_tick_in,
    input  logic [NUM_KEYS-1:0]                               touch_status_in,
    input  logic                                              touch_valid_in,
    output logic [ADDR_WIDTH-1:0]                             bram_addr_out,
    input  logic [SAMPLE_WIDTH-1:0]                           bram_data_in,
    output logic signed [SAMPLE_WIDTH+$clog2(NUM_VOICES)-1:0] mix_out,
    output logic                                              mix_valid_out,
    output logic                                              gate_out,
    output logic [NUM_VOICES-1:0]                             voice_active_out,
    output logic                                              busy_out,
    output logic                                              overrun_out,
    output logic                                              alloc_drop_out
);

    localparam int VIDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int MIX_W  = SAMPLE_WIDTH + $clog2(NUM_VOICES);
    localparam int KEY_W  = $clog2(NUM_KEYS);
    localparam int WAIT_W = (BRAM_LATENCY > 2) ? $clog2(BRAM_LATENCY) : 1;

    state_t                            r_state;
    state_t                            w_state_nxt;
    logic [VIDX_W-1:0]                 r_v;
    logic [WAIT_W-1:0]                 r_wait;
    logic signed [MIX_W-1:0]           r_acc;
    logic signed [MIX_W-1:0]           r_mix;
    logic [ADDR_WIDTH-1:0]             r_addr;
    logic                              r_overrun;
    logic [PHASE_WIDTH-1:0]            r_phase [NUM_VOICES];

    logic [NUM_VOICES-1:0]             w_active;
    logic [NUM_VOICES-1:0][KEY_W-1:0]  w_key;
    logic [NUM_VOICES-1:0]             w_clr;
    logic                              w_drop;
    logic                              w_last;
    logic [VIDX_W-1:0]                 w_v_issue;
    logic [PHASE_WIDTH-1:0]            w_inc;
    logic signed [MIX_W-1:0]           w_acc_nxt;

    // Offset-binary sample to two's complement, sign-extended to mix width
    function automatic logic signed [MIX_W-1:0] to_signed(input logic [SAMPLE_WIDTH-1:0] d);
        logic signed [SAMPLE_WIDTH-1:0] s;
        s = {~d[SAMPLE_WIDTH-1], d[SAMPLE_WIDTH-2:0]};
        return MIX_W'(s);
    endfunction

    voice_allocator #(
        .NUM_VOICES (NUM_VOICES),
        .NUM_KEYS   (NUM_KEYS),
        .KEY_W      (KEY_W)
    ) u_alloc (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .i_touch_status (touch_status_in),
        .i_touch_valid  (touch_valid_in),
        .o_active       (w_active),
        .o_key          (w_key),
        .o_phase_clr    (w_clr),
        .o_drop         (w_drop)
    );

    assign w_last    = (r_v == VIDX_W'(NUM_VOICES - 1));
    assign w_v_issue = (r_state == ST_ACCUM) ? r_v + 1'b1 : '0;
    assign w_inc     = PHASE_WIDTH'(phase_inc(32'(w_key[r_v])));
    assign w_acc_nxt = r_acc + (w_active[r_v] ? to_signed(bram_data_in) : '0);

    // Next-state logic for the per-frame voice walk
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (sample_tick_in) w_state_nxt = ST_ISSUE;
            ST_ISSUE: w_state_nxt = (BRAM_LATENCY > 1) ? ST_WAIT : ST_ACCUM;
            ST_WAIT:  if (r_wait == WAIT_W'(BRAM_LATENCY - 2)) w_state_nxt = ST_ACCUM;
            ST_ACCUM: w_state_nxt = w_last ? ST_DONE : ST_ISSUE;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Voice index, wait counter, accumulator, mix output and read address
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_v       <= '0;
            r_wait    <= '0;
            r_acc     <= '0;
            r_mix     <= '0;
            r_addr    <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= sample_tick_in && (r_state != ST_IDLE);
            case (r_state)
                ST_IDLE: begin
                    r_v    <= '0;
                    r_acc  <= '0;
                    r_wait <= '0;
                end
                ST_ISSUE: r_wait <= '0;
                ST_WAIT:  r_wait <= r_wait + 1'b1;
                ST_ACCUM: begin
                    r_acc <= w_acc_nxt;
                    if (w_last) begin
                        r_mix <= w_acc_nxt;
                    end else begin
                        r_v <= r_v + 1'b1;
                    end
                end
                default: ;
            endcase
            if (w_state_nxt == ST_ISSUE) begin
                r_addr <= r_phase[w_v_issue][PHASE_WIDTH-1 -: ADDR_WIDTH];
            end else if (w_state_nxt == ST_IDLE) begin
                r_addr <= '0;
            end
        end
    end

    // Phase accumulators: allocation/release zeroes win over the ACCUM advance
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                r_phase[v] <= '0;
            end
        end else begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (w_clr[v]) begin
                    r_phase[v] <= '0;
                end else if (r_state == ST_ACCUM && r_v == VIDX_W'(v) && w_active[v]) begin
                    r_phase[v] <= r_phase[v] + w_inc;
                end
            end
        end
    end

    assign bram_addr_out    = r_addr;
    assign mix_out          = r_mix;
    assign mix_valid_out    = (r_state == ST_DONE);
    assign gate_out         = |w_active;
    assign voice_active_out = w_active;
    assign busy_out         = (r_state != ST_IDLE);
    assign overrun_out      = r_overrun;
    assign alloc_drop_out   = w_drop;

endmodule

// File: tb/tb_voice_scheduler.sv
// Directed bench for voice_scheduler: reset, single voice timing and phase,
// allocation/drop, mix arithmetic, overrun, allocation/ACCUM collision and
// mid-frame reset.
module tb_voice_scheduler;

    logic              clk_in = 1'b0;
    logic              rst_in = 1'b0;
    logic              sample_tick_in = 1'b0;
    logic [11:0]       touch_status_in = '0;
    logic              touch_valid_in = 1'b0;
    logic [7:0]        bram_addr_out;
    logic [7:0]        bram_data_in;
    logic signed [9:0] mix_out;
    logic              mix_valid_out;
    logic              gate_out;
    logic [3:0]        voice_active_out;
    logic              busy_out;
    logic              overrun_out;
    logic              alloc_drop_out;

    logic [7:0]        r_bram_val = 8'd128;
    logic [7:0]        r_d1 = 8'd128;
    logic [7:0]        r_d2 = 8'd128;

    int npass  = 0;
    int nfail  = 0;
    int ntotal = 0;

    logic signed [9:0] m;
    logic [7:0]        a1;
    int                n, cyc, ovn, ovc;
    logic [3:0]        act_c10;
    logic [31:0]       ph2_c9, ph2_c10;

    voice_scheduler dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .sample_tick_in   (sample_tick_in),
        .touch_status_in  (touch_status_in),
        .touch_valid_in   (touch_valid_in),
        .bram_addr_out    (bram_addr_out),
        .bram_data_in     (bram_data_in),
        .mix_out          (mix_out),
        .mix_valid_out    (mix_valid_out),
        .gate_out         (gate_out),
        .voice_active_out (voice_active_out),
        .busy_out         (busy_out),
        .overrun_out      (overrun_out),
        .alloc_drop_out   (alloc_drop_out)
    );

    always #5 clk_in = ~clk_in;

    // Two-cycle read latency wavetable model returning a programmable value
    always @(posedge clk_in) begin
        r_d1 <= r_bram_val;
        r_d2 <= r_d1;
    end
    assign bram_data_in = r_d2;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic touch(input logic [11:0] s);
        touch_status_in = s;
        touch_valid_in  = 1'b1;
        step();
        touch_valid_in  = 1'b0;
    endtask

    task automatic run_frame(input logic [7:0] val, output logic signed [9:0] mix,
                             output int vcount, output int vcycle, output logic [7:0] addr1);
        r_bram_val     = val;
        sample_tick_in = 1'b1;
        step();
        sample_tick_in = 1'b0;
        vcount = 0;
        vcycle = 0;
        mix    = '0;
        addr1  = '0;
        for (int c = 1; c <= 15; c++) begin
            if (c == 1) addr1 = bram_addr_out;
            if (mix_valid_out) begin
                vcount++;
                vcycle = c;
                mix    = mix_out;
            end
            step();
        end
    endtask

    initial begin
        // reset state
        step();
        step();
        check("rst_addr",   32'(bram_addr_out), 0);
        check("rst_mix",    32'(mix_out), 0);
        check("rst_valid",  32'(mix_valid_out), 0);
        check("rst_active", 32'(voice_active_out), 0);
        check("rst_ctl",    32'({gate_out, busy_out, overrun_out, alloc_drop_out}), 0);
        rst_in = 1'b1;
        step();

        // frame with no voices active
        run_frame(8'd200, m, n, cyc, a1);
        check("empty_mix",    32'(m), 0);
        check("empty_vcount", 32'(n), 1);
        check("empty_vcycle", 32'(cyc), 13);
        check("empty_gate",   32'(gate_out), 0);

        // single voice on key 9
        touch(12'h200);
        check("k9_active", 32'(voice_active_out), 32'h1);
        check("k9_gate",   32'(gate_out), 1);
        run_frame(8'd255, m, n, cyc, a1);
        check("f1_addr",   32'(a1), 0);
        check("f1_mix",    32'(m), 127);
        check("f1_vcycle", 32'(cyc), 13);
        check("f1_phase0", dut.r_phase[0], 32'd115343360);
        run_frame(8'd255, m, n, cyc, a1);
        check("f2_addr",   32'(a1), 6);
        check("f2_mix",    32'(m), 127);
        check("f2_phase0", dut.r_phase[0], 32'd230686720);
        touch(12'h000);
        check("rel_active", 32'(voice_active_out), 0);
        check("rel_phase0", dut.r_phase[0], 0);

        // five presses into four voices
        touch(12'h01F);
        check("alloc_active", 32'(voice_active_out), 32'hF);
        check("alloc_keys",   32'(dut.w_key), 32'h3210);
        check("alloc_drop",   32'(alloc_drop_out), 1);
        step();
        check("alloc_drop_end", 32'(alloc_drop_out), 0);

        // mix extremes with all four voices active
        run_frame(8'd255, m, n, cyc, a1);
        check("mix_max", 32'(m), 32'd508);
        run_frame(8'd0, m, n, cyc, a1);
        check("mix_min", 32'(m), -32'sd512);

        // release key 1 (and unassigned key 4), then press key 4
        touch(12'h00D);
        check("rel1_active", 32'(voice_active_out), 32'hD);
        touch(12'h01D);
        check("re4_active", 32'(voice_active_out), 32'hF);
        check("re4_keys",   32'(dut.w_key), 32'h3240);
        check("re4_drop",   32'(alloc_drop_out), 0);

        // overrun: second tick five cycles into the frame
        r_bram_val     = 8'd200;
        sample_tick_in = 1'b1;
        step();
        ovn = 0; ovc = 0; n = 0; cyc = 0; m = '0;
        for (int c = 1; c <= 16; c++) begin
            if (overrun_out) begin ovn++; ovc = c; end
            if (mix_valid_out) begin n++; cyc = c; m = mix_out; end
            sample_tick_in = (c == 5);
            step();
        end
        sample_tick_in = 1'b0;
        check("ovr_count",  32'(ovn), 1);
        check("ovr_cycle",  32'(ovc), 6);
        check("ovr_vcount", 32'(n), 1);
        check("ovr_vcycle", 32'(cyc), 13);
        check("ovr_mix",    32'(m), 32'd288);
        step();

        // release key 2 during voice 2's ACCUM cycle
        r_bram_val     = 8'd255;
        sample_tick_in = 1'b1;
        step();
        sample_tick_in = 1'b0;
        n = 0; m = '0; act_c10 = '0; ph2_c9 = '0; ph2_c10 = '1;
        for (int c = 1; c <= 16; c++) begin
            if (c == 9) ph2_c9 = dut.r_phase[2];
            if (c == 10) begin
                act_c10 = voice_active_out;
                ph2_c10 = dut.r_phase[2];
            end
            if (mix_valid_out) begin n++; m = mix_out; end
            touch_status_in = (c == 9) ? 12'h019 : 12'h01D;
            touch_valid_in  = (c == 9);
            step();
        end
        touch_valid_in = 1'b0;
        check("col_ph2_pre", 32'(ph2_c9 != 0), 1);
        check("col_active",  32'(act_c10), 32'hB);
        check("col_phase2",  ph2_c10, 0);
        check("col_mix",     32'(m), 32'd508);
        check("col_vcount",  32'(n), 1);

        // reset asserted mid-frame
        sample_tick_in = 1'b1;
        step();
        sample_tick_in = 1'b0;
        for (int c = 1; c < 6; c++) step();
        check("mid_busy_pre", 32'(busy_out), 1);
        #2;
        rst_in = 1'b0;
        #1;
        check("mid_busy",   32'(busy_out), 0);
        check("mid_active", 32'(voice_active_out), 0);
        check("mid_outs",   32'({bram_addr_out, mix_out, mix_valid_out, gate_out, overrun_out, alloc_drop_out}), 0);
        step();
        step();
        rst_in = 1'b1;
        n = 0;
        for (int c = 0; c < 15; c++) begin
            if (mix_valid_out) n++;
            step();
        end
        check("mid_no_valid", 32'(n), 0);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
